word_game_ctrl: RTL

//  Top-level round sequencer for the word game. Filters keypad events, feeds letters to host_msg_reg
//  (host_key_ready/host_letter), locks the secret word (toggle_state), then runs up to MAX_GUESSES

---
 rtl/word_game_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/word_game_ctrl.sv
// word_game_ctrl: round sequencer for the word game.
// It filters keypad events and feeds the host word, then the guess words, into the datapath.
// It starts each comparison and decides win or lose. On a restart key it clears the datapath
// with a one-cycle gameEnd_host pulse.
// Optional feature: define GAME_TIMEOUT_EN to forfeit a guess after TIMEOUT_CYCLES idle cycles.
// In the default build the macro is undefined and GUESS_ENTRY waits indefinitely.
module word_game_ctrl #(
    parameter int          WORD_LEN       = 5,
    parameter int          MAX_GUESSES    = 6,
    parameter logic [7:0]  ENTER_CODE     = 8'h0D,
    parameter logic [7:0]  RESTART_CODE   = 8'h1B
`ifdef GAME_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
`endif
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       host_rec_ready,
    input  logic       cmp_done,
    input  logic       cmp_match,
    output logic       host_key_ready,
    output logic [7:0] host_letter,
    output logic       toggle_state,
    output logic       guess_key_ready,
    output logic [7:0] guess_letter,
    output logic       cmp_start,
    output logic       gameEnd_host,
    output logic       game_win,
    output logic       game_lose,
    output logic [2:0] guess_count,
    output logic [2:0] letter_count
);

    // Counters are 3 bits wide, so WORD_LEN and MAX_GUESSES must not exceed 7.
    localparam logic [2:0] WORD_LEN_C  = 3'(WORD_LEN);
    localparam logic [2:0] MAX_GUESS_C = 3'(MAX_GUESSES);
    localparam logic [7:0] BLANK_CHAR  = 8'h5F;

    typedef enum logic [2:0] {
        HOST_ENTRY,
        HOST_WAIT,
        GUESS_ENTRY,
        COMPARE,
        WIN,
        LOSE,
        RESTART
    } state_t;

    state_t     state, state_d;

    logic       host_key_ready_d;
    logic [7:0] host_letter_d;
    logic       toggle_state_d;
    logic       guess_key_ready_d;
    logic [7:0] guess_letter_d;
    logic       cmp_start_d;
    logic       gameEnd_host_d;
    logic       game_win_d;
    logic       game_lose_d;
    logic [2:0] guess_count_d;
    logic [2:0] letter_count_d;

    logic       is_letter;
    logic       is_enter;
    logic       is_restart;
    logic       has_room;
    logic       word_full;

    // Guess counter never wraps: it sticks at the guess limit.
    function automatic logic [2:0] sat_inc_guess(input logic [2:0] cnt);
        if (cnt >= MAX_GUESS_C) begin
            return MAX_GUESS_C;
        end
        return cnt + 3'd1;
    endfunction

    assign is_letter  = key_valid && (key_code >= 8'h41) && (key_code <= 8'h5A);
    assign is_enter   = key_valid && (key_code == ENTER_CODE);
    assign is_restart = key_valid && (key_code == RESTART_CODE);
    assign has_room   = (letter_count < WORD_LEN_C);
    assign word_full  = (letter_count == WORD_LEN_C);

`ifdef GAME_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

    logic [23:0] idle_cnt;
    logic        key_accepted;
    logic        timeout_hit;

    assign key_accepted = (state == GUESS_ENTRY) &&
                          ((is_letter && has_room) || (is_enter && word_full));
    assign timeout_hit  = (state == GUESS_ENTRY) && (idle_cnt == TIMEOUT_LAST);

    // Idle counter: counts GUESS_ENTRY cycles without an accepted key and restarts on entry and on each forfeit.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            idle_cnt <= 24'd0;
        end else if ((state != GUESS_ENTRY) || key_accepted || timeout_hit) begin
            idle_cnt <= 24'd0;
        end else begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end
`endif

    // Next-state and next-output logic; keys are always judged against the current state.
    always_comb begin
        state_d           = state;
        host_key_ready_d  = 1'b0;
        host_letter_d     = host_letter;
        toggle_state_d    = 1'b0;
        guess_key_ready_d = 1'b0;
        guess_letter_d    = guess_letter;
        cmp_start_d       = 1'b0;
        gameEnd_host_d    = 1'b0;
        guess_count_d     = guess_count;
        letter_count_d    = letter_count;

        case (state)
            HOST_ENTRY: begin
                if (is_letter && has_room) begin
                    host_key_ready_d = 1'b1;
                    host_letter_d    = key_code;
                    letter_count_d   = letter_count + 3'd1;
                end else if (is_enter && word_full) begin
                    toggle_state_d = 1'b1;
                    letter_count_d = 3'd0;
                    state_d        = HOST_WAIT;
                end
            end
            HOST_WAIT: begin
                if (host_rec_ready) begin
                    state_d = GUESS_ENTRY;
                end
            end
            GUESS_ENTRY: begin
                if (is_letter && has_room) begin
                    guess_key_ready_d = 1'b1;
                    guess_letter_d    = key_code;
                    letter_count_d    = letter_count + 3'd1;
                end else if (is_enter && word_full) begin
                    cmp_start_d    = 1'b1;
                    guess_count_d  = sat_inc_guess(guess_count);
                    letter_count_d = 3'd0;
                    state_d        = COMPARE;
                end
`ifdef GAME_TIMEOUT_EN
                else if (timeout_hit) begin
                    // Forfeit: the guess is spent without a comparison.
                    guess_count_d  = sat_inc_guess(guess_count);
                    letter_count_d = 3'd0;
                    if (sat_inc_guess(guess_count) == MAX_GUESS_C) begin
                        state_d = LOSE;
                    end
                end
`endif
            end
            COMPARE: begin
                if (cmp_done) begin
                    if (cmp_match) begin
                        state_d = WIN;
                    end else if (guess_count == MAX_GUESS_C) begin
                        state_d = LOSE;
                    end else begin
                        state_d = GUESS_ENTRY;
                    end
                end
            end
            WIN, LOSE: begin
                if (is_restart) begin
                    gameEnd_host_d = 1'b1;
                    guess_count_d  = 3'd0;
                    letter_count_d = 3'd0;
                    state_d        = RESTART;
                end
            end
            RESTART: begin
                state_d = HOST_ENTRY;
            end
            default: begin
                state_d = HOST_ENTRY;
            end
        endcase

        game_win_d  = (state_d == WIN);
        game_lose_d = (state_d == LOSE);
    end

    // State and registered outputs; nRst returns everything to idle without a gameEnd_host pulse.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state           <= HOST_ENTRY;
            host_key_ready  <= 1'b0;
            host_letter     <= BLANK_CHAR;
            toggle_state    <= 1'b0;
            guess_key_ready <= 1'b0;
            guess_letter    <= BLANK_CHAR;
            cmp_start       <= 1'b0;
            gameEnd_host    <= 1'b0;
            game_win        <= 1'b0;
            game_lose       <= 1'b0;
            guess_count     <= 3'd0;
            letter_count    <= 3'd0;
        end else begin
            state           <= state_d;
            host_key_ready  <= host_key_ready_d;
            host_letter     <= host_letter_d;
            toggle_state    <= toggle_state_d;
            guess_key_ready <= guess_key_ready_d;
            guess_letter    <= guess_letter_d;
            cmp_start       <= cmp_start_d;
            gameEnd_host    <= gameEnd_host_d;
            game_win        <= game_win_d;
            game_lose       <= game_lose_d;
            guess_count     <= guess_count_d;
            letter_count    <= letter_count_d;
        end
    end

endmodule
